sat_round: RTL and testbench



---
 rtl/sat_round.sv | 119 +++++++++++
 tb/tb_sat_round.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sat_round.sv
// sat_round: multi-lane round-then-saturate width reducer with ready/valid flow.
// Define SAT_ROUND_COUNTER_EN to build the saturated-beat counter.
module sat_round #(
    parameter int S_WIDTH  = 32,
    parameter int M_WIDTH  = 16,
    parameter int SHIFT    = 0,
    parameter int CHANNELS = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   round_mode,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [CHANNELS*S_WIDTH-1:0]  s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [CHANNELS*M_WIDTH-1:0]  m_data,
    output logic [CHANNELS-1:0]          m_overflow,
    input  logic                         count_clear,
    output logic [31:0]                  sat_count
);

    localparam int RW = S_WIDTH + 1 - SHIFT;

    logic                         en;
    logic                         v1;
    logic [CHANNELS*RW-1:0]       r1_q;
    logic [CHANNELS*RW-1:0]       r_d;
    logic [CHANNELS*M_WIDTH-1:0]  y_d;
    logic [CHANNELS-1:0]          ov_d;

    assign en      = !m_valid || m_ready;
    assign s_ready = en;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        logic [S_WIDTH:0] xe;
        logic [RW-1:0]    r;
        logic             fits;

        assign xe = {s_data[k*S_WIDTH+S_WIDTH-1], s_data[k*S_WIDTH +: S_WIDTH]};

        if (SHIFT == 0) begin : g_pass
            logic [1:0] unused_mode;
            assign unused_mode     = round_mode;
            assign r_d[k*RW +: RW] = xe;
        end else begin : g_rnd
            localparam logic [S_WIDTH:0] HALF = (S_WIDTH+1)'(1) << (SHIFT - 1);
            logic [S_WIDTH:0] up;
            logic             tie;
            logic [RW-1:0]    rr;

            // Adding half cannot overflow: xe carries one spare sign bit.
            assign up  = xe + HALF;
            assign tie = xe[SHIFT-1:0] == HALF[SHIFT-1:0];

            always_comb begin
                rr = xe[S_WIDTH:SHIFT];
                unique case (round_mode)
                    2'd1:    rr = up[S_WIDTH:SHIFT];
                    2'd2:    rr = up[S_WIDTH:SHIFT] & ~RW'(tie);
                    default: ;
                endcase
            end

            assign r_d[k*RW +: RW] = rr;
        end

        // Fits when every bit from the output sign bit upward agrees.
        assign r    = r1_q[k*RW +: RW];
        assign fits = (&r[RW-1:M_WIDTH-1]) || !(|r[RW-1:M_WIDTH-1]);

        assign ov_d[k] = !fits;
        assign y_d[k*M_WIDTH +: M_WIDTH] =
            fits      ? r[M_WIDTH-1:0] :
            r[RW-1]   ? {1'b1, {(M_WIDTH-1){1'b0}}} :
                        {1'b0, {(M_WIDTH-1){1'b1}}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1         <= 1'b0;
            r1_q       <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_overflow <= '0;
        end else if (en) begin
            v1      <= s_valid;
            m_valid <= v1;
            if (s_valid) begin
                r1_q <= r_d;
            end
            if (v1) begin
                m_data     <= y_d;
                m_overflow <= ov_d;
            end
        end
    end

`ifdef SAT_ROUND_COUNTER_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (count_clear) begin
            cnt_q <= '0;
        end else if (m_valid && m_ready && (|m_overflow) && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign sat_count = cnt_q;
`else
    logic unused_clear;
    assign unused_clear = count_clear;
    assign sat_count    = '0;
`endif

endmodule

// File: tb/tb_sat_round.sv
// tb_sat_round: vector table plus scoreboard bench for sat_round.
// Runs with S_WIDTH=16, M_WIDTH=8, SHIFT=4, CHANNELS=2.
module tb_sat_round;

    localparam int SW = 16;
    localparam int MW = 8;
    localparam int SH = 4;
    localparam int CH = 2;

`ifdef SAT_ROUND_COUNTER_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        round_mode;
    logic              s_valid;
    logic              s_ready;
    logic [CH*SW-1:0]  s_data;
    logic              m_valid;
    logic              m_ready;
    logic [CH*MW-1:0]  m_data;
    logic [CH-1:0]     m_overflow;
    logic              count_clear;
    logic [31:0]       sat_count;

    sat_round #(
        .S_WIDTH(SW), .M_WIDTH(MW), .SHIFT(SH), .CHANNELS(CH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .round_mode(round_mode),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_overflow(m_overflow),
        .count_clear(count_clear),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] l0;
        logic [15:0] l1;
        logic [1:0]  md;
        logic [7:0]  e0;
        logic [7:0]  e1;
        logic [1:0]  eov;
    } vec_t;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  ov;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   stall_cnt = 0;
    bit   done;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Reference: floor division and remainder, rounding decided from the remainder.
    function automatic logic [8:0] model(input logic [15:0] x, input logic [1:0] md);
        int v, fl, rem, r;
        v   = $signed(x);
        fl  = v >>> 4;
        rem = v - fl * 16;
        case (md)
            2'd1:    r = fl + ((rem >= 8) ? 1 : 0);
            2'd2:    r = fl + ((rem > 8 || (rem == 8 && (fl % 2) != 0)) ? 1 : 0);
            default: r = fl;
        endcase
        if (r > 127)  return {1'b1, 8'h7F};
        if (r < -128) return {1'b1, 8'h80};
        return {1'b0, 8'(r)};
    endfunction

    // Scoreboard / stall monitor, sampled mid-cycle.
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic [1:0]  prev_ov;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (m_valid && m_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat data=%h ovf=%b", m_data, m_overflow);
                end else begin
                    e = sbq.pop_front();
                    check("beat", {14'd0, m_data, m_overflow}, {14'd0, e.d, e.ov});
                end
            end
            if (prev_stall)
                check("stall_hold", {13'd0, m_valid, m_data, m_overflow},
                      {13'd0, 1'b1, prev_data, prev_ov});
            if (m_valid && !m_ready) begin
                stall_cnt++;
                check("s_ready_stall", {31'd0, s_ready}, 32'd0);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_ov    = m_overflow;
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] md, input logic [7:0] e0,
                        input logic [7:0] e1, input logic [1:0] eov);
        bit acc = 1'b0;
        int n = 0;
        s_data     = {b, a};
        round_mode = md;
        s_valid    = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        s_valid = 1'b0;
        if (acc) begin
            sbq.push_back({e1, e0, eov});
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=not_accepted want=accepted");
        end
    endtask

    task automatic send_m(input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] md);
        logic [8:0] ra, rb;
        ra = model(a, md);
        rb = model(b, md);
        send(a, b, md, ra[7:0], rb[7:0], {rb[8], ra[8]});
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() > 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", sbq.size(), 32'd0);
    endtask

    task automatic latency_check();
        @(negedge clk);
        check("lat_early", {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        check("lat_valid", {31'd0, m_valid}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{16'h0128, 16'hFED8, 2'd0, 8'h12, 8'hED, 2'b00};
        tbl[1] = '{16'h0018, 16'h0028, 2'd1, 8'h02, 8'h03, 2'b00};
        tbl[2] = '{16'h0018, 16'h0028, 2'd2, 8'h02, 8'h02, 2'b00};
        tbl[3] = '{16'h0018, 16'h0028, 2'd3, 8'h01, 8'h02, 2'b00};
        tbl[4] = '{16'h7FFF, 16'h8000, 2'd0, 8'h7F, 8'h80, 2'b11};
        tbl[5] = '{16'h07F8, 16'h0000, 2'd1, 8'h7F, 8'h00, 2'b01};
        tbl[6] = '{16'h07F8, 16'h0000, 2'd0, 8'h7F, 8'h00, 2'b00};
        tbl[7] = '{16'hFFF8, 16'hFFE8, 2'd2, 8'h00, 8'hFE, 2'b00};
        tbl[8] = '{16'hF800, 16'h07F0, 2'd1, 8'h80, 8'h7F, 2'b00};
        tbl[9] = '{16'hF7F8, 16'hF7F7, 2'd1, 8'h80, 8'h80, 2'b10};

        reset       = 1'b1;
        round_mode  = 2'd0;
        s_valid     = 1'b0;
        s_data      = '0;
        m_ready     = 1'b1;
        count_clear = 1'b0;
        #12;
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {16'd0, m_data}, 32'd0);
        check("rst_m_ovf", {30'd0, m_overflow}, 32'd0);
        check("rst_sat_count", sat_count, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            send(tbl[i].l0, tbl[i].l1, tbl[i].md, tbl[i].e0, tbl[i].e1, tbl[i].eov);
            latency_check();
            drain();
        end

        // Backpressure: ten back-to-back beats with a five-cycle stall.
        stall_cnt = 0;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send_m(16'(i * 16'h0123), 16'(16'hF000 + i * 16'h0357), 2'(i % 3));
                done = 1'b1;
            end
            begin
                int c = 0;
                while (!done) begin
                    @(posedge clk);
                    #1;
                    c++;
                    m_ready = !(c >= 3 && c <= 7);
                end
                m_ready = 1'b1;
            end
        join
        drain();
        check("stall_seen", {31'd0, stall_cnt > 0}, 32'd1);

        // Random stream with random downstream readiness.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send_m(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    m_ready = 1'($urandom_range(0, 1));
                end
                m_ready = 1'b1;
            end
        join
        drain();

        // Counter sequence.
        count_clear = 1'b1;
        @(posedge clk);
        #1;
        count_clear = 1'b0;
        check("cnt_cleared", sat_count, 32'd0);
        for (int i = 0; i < 3; i++)
            send(16'h7FFF, 16'h8000, 2'd0, 8'h7F, 8'h80, 2'b11);
        drain();
        check("cnt_three", sat_count, 32'(3 * CNT_EN));
        send(16'h7FFF, 16'h8000, 2'd0, 8'h7F, 8'h80, 2'b11);
        @(posedge clk);
        #1;
        count_clear = 1'b1;
        @(posedge clk);
        #1;
        count_clear = 1'b0;
        check("cnt_clear_wins", sat_count, 32'd0);
        check("cnt_clear_drain", sbq.size(), 32'd0);
        send(16'h07F8, 16'h0000, 2'd1, 8'h7F, 8'h00, 2'b01);
        drain();
        check("cnt_one", sat_count, 32'(CNT_EN));
        send(16'h0128, 16'hFED8, 2'd0, 8'h12, 8'hED, 2'b00);
        drain();
        check("cnt_no_ovf", sat_count, 32'(CNT_EN));

        // Reset with two beats in flight.
        send(16'h7FFF, 16'h0100, 2'd0, 8'h7F, 8'h10, 2'b01);
        send(16'h0200, 16'h0300, 2'd0, 8'h20, 8'h30, 2'b00);
        check("pre_reset_valid", {31'd0, m_valid}, 32'd1);
        reset = 1'b1;
        sbq.delete();
        #1;
        check("reset_m_valid", {31'd0, m_valid}, 32'd0);
        check("reset_sat_count", sat_count, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {31'd0, m_valid}, 32'd0);
        @(posedge clk);
        #1;
        send(16'h0018, 16'h0028, 2'd2, 8'h02, 8'h02, 2'b00);
        latency_check();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
